// File: rtl/id_ctrl_stage.sv
// ---------------------------------------------------------------------------
// id_ctrl_stage
//   Main-control stage of the pipelined MIPS core. Decodes the IF/ID
//   instruction, resolves the destination register and registers the full
//   control bundle into ID/EX. Detects load-use hazards (combinational
//   stall_out), inserts bubbles on flush / stall / illegal opcode and keeps a
//   saturating count of stall cycles.
//
//   Optional feature macro: ID_CTRL_HAZARD_EN
//     defined   : load-use detection, stall bubbles and stall_cnt are active.
//     undefined : stall_out and stall_cnt are tied to 0.
//
//   Ports
//     clk, rst_n       clock, asynchronous active-low reset
//     id_valid         IF/ID holds a valid instruction
//     id_instr         instruction word in ID
//     flush            squash the instruction in ID (taken branch/jump)
//     stall_out        hold PC and IF/ID this cycle (combinational)
//     ex_*             registered ID/EX control bundle and register fields
//     ex_illegal       one-cycle pulse when an illegal opcode is accepted
//     illegal_sticky   set by any accepted illegal opcode, cleared by reset
//     stall_cnt        saturating stall-cycle counter
// ---------------------------------------------------------------------------
module id_ctrl_stage #(
    parameter int AW       = 5,
    parameter int LINK_REG = 31,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [31:0]      id_instr,
    input  logic             flush,
    output logic             stall_out,
    output logic             ex_valid,
    output logic             ex_reg_dst,
    output logic             ex_alu_src,
    output logic             ex_mem_to_reg,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic             ex_mem_write,
    output logic             ex_branch,
    output logic             ex_branch_ne,
    output logic             ex_jump,
    output logic             ex_jal,
    output logic [2:0]       ex_alu_op,
    output logic [AW-1:0]    ex_rs,
    output logic [AW-1:0]    ex_rt,
    output logic [AW-1:0]    ex_dest,
    output logic             ex_illegal,
    output logic             illegal_sticky,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    logic [5:0]    opcode_p0;
    logic [AW-1:0] rs_p0, rt_p0, rd_p0, dest_p0;
    logic          legal_p0;
    logic          reg_dst_p0, alu_src_p0, mem_to_reg_p0, reg_write_p0;
    logic          mem_read_p0, mem_write_p0, branch_p0, branch_ne_p0;
    logic          jump_p0, jal_p0;
    logic [2:0]    alu_op_p0;
    logic          bubble_p0, ill_take_p0;

    assign opcode_p0 = id_instr[31:26];
    assign rs_p0     = id_instr[21 +: AW];
    assign rt_p0     = id_instr[16 +: AW];
    assign rd_p0     = id_instr[11 +: AW];

    always_comb begin
        legal_p0      = 1'b1;
        reg_dst_p0    = 1'b0;
        alu_src_p0    = 1'b0;
        mem_to_reg_p0 = 1'b0;
        reg_write_p0  = 1'b0;
        mem_read_p0   = 1'b0;
        mem_write_p0  = 1'b0;
        branch_p0     = 1'b0;
        branch_ne_p0  = 1'b0;
        jump_p0       = 1'b0;
        jal_p0        = 1'b0;
        alu_op_p0     = 3'b000;
        dest_p0       = '0;
        case (opcode_p0)
            OP_RTYPE: begin
                // The all-zero word is the canonical nop: no controls at all.
                if (id_instr != 32'd0) begin
                    reg_dst_p0   = 1'b1;
                    reg_write_p0 = 1'b1;
                    alu_op_p0    = 3'b010;
                    dest_p0      = rd_p0;
                end
            end
            OP_LW: begin
                alu_src_p0    = 1'b1;
                mem_read_p0   = 1'b1;
                mem_to_reg_p0 = 1'b1;
                reg_write_p0  = 1'b1;
                dest_p0       = rt_p0;
            end
            OP_SW: begin
                alu_src_p0   = 1'b1;
                mem_write_p0 = 1'b1;
            end
            OP_BEQ: begin
                branch_p0 = 1'b1;
                alu_op_p0 = 3'b001;
            end
            OP_BNE: begin
                branch_p0    = 1'b1;
                branch_ne_p0 = 1'b1;
                alu_op_p0    = 3'b001;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                alu_src_p0   = 1'b1;
                reg_write_p0 = 1'b1;
                dest_p0      = rt_p0;
                case (opcode_p0)
                    OP_ANDI: alu_op_p0 = 3'b011;
                    OP_ORI:  alu_op_p0 = 3'b100;
                    OP_SLTI: alu_op_p0 = 3'b101;
                    default: alu_op_p0 = 3'b000;
                endcase
            end
            OP_J: begin
                jump_p0 = 1'b1;
            end
            OP_JAL: begin
                jump_p0      = 1'b1;
                jal_p0       = 1'b1;
                reg_write_p0 = 1'b1;
                dest_p0      = AW'(LINK_REG);
            end
            default: legal_p0 = 1'b0;
        endcase
        // Writes to $0 are architecturally discarded; drop them here so the
        // forwarding/hazard logic downstream never sees them.
        if (dest_p0 == '0)
            reg_write_p0 = 1'b0;
    end

`ifdef ID_CTRL_HAZARD_EN
    logic reads_rs_p0, reads_rt_p0, hazard_p0;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign reads_rs_p0 = (opcode_p0 != OP_J) && (opcode_p0 != OP_JAL);
    assign reads_rt_p0 = (opcode_p0 == OP_RTYPE) || (opcode_p0 == OP_SW) ||
                         (opcode_p0 == OP_BEQ)   || (opcode_p0 == OP_BNE);

    assign hazard_p0 = id_valid & ex_valid & ex_mem_read & (ex_dest != '0) &
                       (((ex_dest == rs_p0) & reads_rs_p0) |
                        ((ex_dest == rt_p0) & reads_rt_p0));

    // Flush outranks the stall: the dependent instruction is squashed anyway.
    assign stall_out = rst_n & hazard_p0 & ~flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_out)
            stall_cnt <= sat_inc(stall_cnt);
    end
`else
    assign stall_out = 1'b0;
    assign stall_cnt = '0;
`endif

    assign bubble_p0   = flush | stall_out | (id_valid & ~legal_p0);
    assign ill_take_p0 = id_valid & ~legal_p0 & ~flush & ~stall_out;

    // ---- ID -> ID/EX boundary ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || bubble_p0) begin
            if (!rst_n || bubble_p0) begin
                ex_valid      <= 1'b0;
                ex_reg_dst    <= 1'b0;
                ex_alu_src    <= 1'b0;
                ex_mem_to_reg <= 1'b0;
                ex_reg_write  <= 1'b0;
                ex_mem_read   <= 1'b0;
                ex_mem_write  <= 1'b0;
                ex_branch     <= 1'b0;
                ex_branch_ne  <= 1'b0;
                ex_jump       <= 1'b0;
                ex_jal        <= 1'b0;
                ex_alu_op     <= 3'b000;
                ex_rs         <= '0;
                ex_rt         <= '0;
                ex_dest       <= '0;
            end
        end else begin
            ex_valid      <= id_valid;
            ex_reg_dst    <= reg_dst_p0;
            ex_alu_src    <= alu_src_p0;
            ex_mem_to_reg <= mem_to_reg_p0;
            ex_reg_write  <= reg_write_p0;
            ex_mem_read   <= mem_read_p0;
            ex_mem_write  <= mem_write_p0;
            ex_branch     <= branch_p0;
            ex_branch_ne  <= branch_ne_p0;
            ex_jump       <= jump_p0;
            ex_jal        <= jal_p0;
            ex_alu_op     <= alu_op_p0;
            ex_rs         <= rs_p0;
            ex_rt         <= rt_p0;
            ex_dest       <= dest_p0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_illegal     <= 1'b0;
            illegal_sticky <= 1'b0;
        end else begin
            ex_illegal     <= ill_take_p0;
            illegal_sticky <= illegal_sticky | ill_take_p0;
        end
    end

endmodule
